crack_ctrl: RTL and testbench



---
 rtl/arc4_pkg.sv | 34 +++
 rtl/crack_ctrl_pt_scan.sv | 79 +++++++
 rtl/crack_ctrl.sv | 117 +++++++++++
 tb/tb_crack_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arc4_pkg.sv
// Shared definitions for the ARC4 key-search datapath.
//   KEY_W / ADDR_W / DATA_W : key, plaintext address and plaintext data widths
//   CHAR_LO / CHAR_HI       : default printable-ASCII acceptance window
//   crack_state_t           : key-search controller states (fixed legacy encoding)
//   is_printable()          : inclusive unsigned range test for one plaintext byte
package arc4_pkg;

   localparam int unsigned KEY_W  = 24;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 8;

   localparam logic [DATA_W-1:0] CHAR_LO = 8'h20;
   localparam logic [DATA_W-1:0] CHAR_HI = 8'h7E;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_START     = 4'd1,
      ST_WAIT_BUSY = 4'd2,
      ST_WAIT_DONE = 4'd3,
      ST_RD_LEN    = 4'd4,
      ST_LAT_LEN   = 4'd5,
      ST_RD_CH     = 4'd6,
      ST_LAT_CH    = 4'd7,
      ST_NEXT      = 4'd8,
      ST_DONE      = 4'd9
   } crack_state_t;

   function automatic logic is_printable(input logic [DATA_W-1:0] b,
                                         input logic [DATA_W-1:0] lo,
                                         input logic [DATA_W-1:0] hi);
      return (b >= lo) && (b <= hi);
   endfunction

endpackage

// File: rtl/crack_ctrl_pt_scan.sv
// pt_scan: walks the length-prefixed plaintext memory once per start pulse.
//   clk, rst     : clock, synchronous active-high reset
//   start_i      : one-cycle pulse, begins a scan (RD_LEN)
//   pt_rddata_i  : plaintext read data, one cycle after pt_addr_o
//   pt_addr_o    : plaintext read address (idx while reading bytes, else 0)
//   done_o       : one-cycle pulse when the verdict is known
//   pass_o       : valid with done_o; 1 = every byte inside [CHAR_LO, CHAR_HI]
module pt_scan import arc4_pkg::*; #(
   parameter logic [DATA_W-1:0] CHAR_LO = arc4_pkg::CHAR_LO,
   parameter logic [DATA_W-1:0] CHAR_HI = arc4_pkg::CHAR_HI
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [DATA_W-1:0] pt_rddata_i,
   output logic [ADDR_W-1:0] pt_addr_o,
   output logic              done_o,
   output logic              pass_o
);

   crack_state_t      state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [DATA_W-1:0] len_q, len_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      done_o  = 1'b0;
      pass_o  = 1'b0;
      case (state_q)
         ST_IDLE:    if (start_i) state_d = ST_RD_LEN;
         ST_RD_LEN:  state_d = ST_LAT_LEN;
         ST_LAT_LEN: begin
            len_d = pt_rddata_i;
            if (pt_rddata_i == '0) begin
               done_o  = 1'b1;
               pass_o  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               idx_d   = ADDR_W'(1);
               state_d = ST_RD_CH;
            end
         end
         ST_RD_CH:   state_d = ST_LAT_CH;
         ST_LAT_CH: begin
            // Early reject on the first out-of-range byte; idx==len is checked
            // before the increment so len=255 stops at 255 without wrapping.
            if (!is_printable(pt_rddata_i, CHAR_LO, CHAR_HI)) begin
               done_o  = 1'b1;
               state_d = ST_IDLE;
            end else if (idx_q == len_q) begin
               done_o  = 1'b1;
               pass_o  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               idx_d   = idx_q + ADDR_W'(1);
               state_d = ST_RD_CH;
            end
         end
         default:    state_d = ST_IDLE;
      endcase
   end

   assign pt_addr_o = (state_q == ST_RD_CH || state_q == ST_LAT_CH) ? idx_q : '0;

endmodule

// File: rtl/crack_ctrl.sv
// crack_ctrl: brute-force key search driving the arc4 decrypt core.
//   clk, rst   : clock, synchronous active-high reset
//   en / rdy   : start handshake (en sampled only while rdy=1)
//   key        : last key tried, final when rdy=1 after a search
//   key_valid  : 1 = key decrypts to printable text, 0 = key space exhausted
//   a4_en      : one-cycle start pulse to arc4
//   a4_rdy     : arc4 idle/done
//   a4_key     : key presented to arc4, stable for the whole decryption
//   pt_addr    : plaintext read address (non-zero only while scanning)
//   pt_rddata  : plaintext read data, one-cycle registered latency
module crack_ctrl import arc4_pkg::*; #(
   parameter logic [KEY_W-1:0]  KEY_START = 24'h000000,
   parameter logic [KEY_W-1:0]  KEY_LAST  = 24'hFFFFFF,
   parameter logic [DATA_W-1:0] CHAR_LO   = arc4_pkg::CHAR_LO,
   parameter logic [DATA_W-1:0] CHAR_HI   = arc4_pkg::CHAR_HI
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   output logic              rdy,
   output logic [KEY_W-1:0]  key,
   output logic              key_valid,
   output logic              a4_en,
   input  logic              a4_rdy,
   output logic [KEY_W-1:0]  a4_key,
   output logic [ADDR_W-1:0] pt_addr,
   input  logic [DATA_W-1:0] pt_rddata
);

   crack_state_t     state_q, state_d;
   logic [KEY_W-1:0] cur_key_q, cur_key_d;
   logic             valid_q, valid_d;
   logic             scan_start, scan_done, scan_pass;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cur_key_q <= '0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_key_q <= cur_key_d;
         valid_q   <= valid_d;
      end
   end

   // ST_RD_LEN here covers the whole RD_LEN..LAT_CH loop, which is sequenced
   // inside pt_scan; this FSM only waits for its done pulse.
   always_comb begin
      state_d    = state_q;
      cur_key_d  = cur_key_q;
      valid_d    = valid_q;
      a4_en      = 1'b0;
      scan_start = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (en) begin
               cur_key_d = KEY_START;
               valid_d   = 1'b0;
               state_d   = ST_START;
            end
         end
         ST_START: begin
            if (a4_rdy) begin
               a4_en   = 1'b1;
               state_d = ST_WAIT_BUSY;
            end
         end
         // Do not trust a4_rdy until the core has been seen busy.
         ST_WAIT_BUSY: if (!a4_rdy) state_d = ST_WAIT_DONE;
         ST_WAIT_DONE: begin
            if (a4_rdy) begin
               scan_start = 1'b1;
               state_d    = ST_RD_LEN;
            end
         end
         ST_RD_LEN: begin
            if (scan_done) begin
               if (scan_pass) begin
                  valid_d = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_NEXT;
               end
            end
         end
         ST_NEXT: begin
            if (cur_key_q == KEY_LAST) begin
               state_d = ST_DONE;
            end else begin
               cur_key_d = cur_key_q + KEY_W'(1);
               state_d   = ST_START;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   pt_scan #(
      .CHAR_LO (CHAR_LO),
      .CHAR_HI (CHAR_HI)
   ) u_scan (
      .clk         (clk),
      .rst         (rst),
      .start_i     (scan_start),
      .pt_rddata_i (pt_rddata),
      .pt_addr_o   (pt_addr),
      .done_o      (scan_done),
      .pass_o      (scan_pass)
   );

   assign rdy       = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign key       = cur_key_q;
   assign key_valid = valid_q;
   assign a4_key    = cur_key_q;

endmodule

// File: tb/tb_crack_ctrl.sv
// Bench for crack_ctrl: behavioural arc4 (programmable hold/busy, per-key
// plaintext table) plus a reference that derives the expected hit key,
// bytes examined per key and scan latencies from the acceptance rules.
module tb_crack_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        en0, rdy0, kv0, a4_en0, a4_rdy0;
   logic [23:0] key0, a4_key0;
   logic [7:0]  pt_addr0, pt_rddata0;
   logic        en1, rdy1, kv1, a4_en1, a4_rdy1;
   logic [23:0] key1, a4_key1;
   logic [7:0]  pt_addr1, pt_rddata1;

   crack_ctrl dut0 (
      .clk(clk), .rst(rst), .en(en0), .rdy(rdy0), .key(key0), .key_valid(kv0),
      .a4_en(a4_en0), .a4_rdy(a4_rdy0), .a4_key(a4_key0),
      .pt_addr(pt_addr0), .pt_rddata(pt_rddata0));

   crack_ctrl #(.KEY_START(24'hFFFFFE), .KEY_LAST(24'hFFFFFF)) dut1 (
      .clk(clk), .rst(rst), .en(en1), .rdy(rdy1), .key(key1), .key_valid(kv1),
      .a4_en(a4_en1), .a4_rdy(a4_rdy1), .a4_key(a4_key1),
      .pt_addr(pt_addr1), .pt_rddata(pt_rddata1));

   int unsigned n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // ---------------- reference: plaintext per key and acceptance rules
   logic [7:0] ptab [16][256];

   function automatic logic [7:0] byte_at(input logic [23:0] k, input int unsigned i);
      logic [7:0] ii;
      ii = i[7:0];
      if (k < 24'd16) return ptab[k[3:0]][ii];
      return (i == 0) ? 8'd1 : 8'd0;
   endfunction

   function automatic bit good(input logic [7:0] b);
      return (b >= 8'h20) && (b <= 8'h7E);
   endfunction

   // bytes examined before a verdict (index of first bad byte, else len)
   function automatic int unsigned exam(input logic [23:0] k);
      int unsigned n;
      n = byte_at(k, 0);
      for (int unsigned i = 1; i <= n; i++)
         if (!good(byte_at(k, i))) return i;
      return n;
   endfunction

   function automatic bit ok(input logic [23:0] k);
      int unsigned n;
      n = byte_at(k, 0);
      for (int unsigned i = 1; i <= n; i++)
         if (!good(byte_at(k, i))) return 1'b0;
      return 1'b1;
   endfunction

   // ---------------- behavioural arc4 for dut0
   int unsigned hold_len = 0, busy_len = 5, t = 0, cyc = 0;
   bit          act = 1'b0;
   logic [7:0]  mem0 [256];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      pt_rddata0 <= mem0[pt_addr0];
      if (rst) begin
         a4_rdy0 <= 1'b1;
         act     <= 1'b0;
         t       <= 0;
      end else if (a4_en0) begin
         act     <= 1'b1;
         t       <= 1;
         a4_rdy0 <= (hold_len != 0);
         for (int unsigned i = 0; i < 256; i++) mem0[i] <= byte_at(a4_key0, i);
      end else if (act) begin
         t <= t + 1;
         if (t < hold_len) a4_rdy0 <= 1'b1;
         else if (t < hold_len + busy_len) a4_rdy0 <= 1'b0;
         else begin
            a4_rdy0 <= 1'b1;
            act     <= 1'b0;
         end
      end
   end

   // ---------------- behavioural arc4 for dut1: every key gives len=1, byte 0x00
   int unsigned b1 = 0;
   always @(posedge clk) begin
      pt_rddata1 <= (pt_addr1 == 8'd0) ? 8'd1 : 8'd0;
      if (rst) begin
         a4_rdy1 <= 1'b1;
         b1      <= 0;
      end else if (a4_en1) begin
         a4_rdy1 <= 1'b0;
         b1      <= 3;
      end else if (b1 != 0) begin
         b1 <= b1 - 1;
         if (b1 == 1) a4_rdy1 <= 1'b1;
      end
   end

   // ---------------- monitor: records attempts, widths, stability
   typedef struct {
      logic [23:0] key;
      int unsigned maxa;
      int unsigned gap;
   } att_t;
   att_t        att_q [$];
   logic [23:0] keys_q [$];
   int unsigned n_en0 = 0, n_en1 = 0, wide_cnt = 0, stab_err = 0, max_addr = 0, rise_cyc = 0;
   bit          pend = 1'b0, prev_en = 1'b0, prev_rdy = 1'b1;
   logic [23:0] lat_key = '0;

   always @(negedge clk) begin
      att_t a;
      if (!rst && a4_en1) n_en1++;
      if (rst) begin
         pend     = 1'b0;
         prev_en  = 1'b0;
         prev_rdy = a4_rdy0;
         max_addr = 0;
      end else begin
         if (prev_en && a4_en0) wide_cnt++;
         if (32'(pt_addr0) > max_addr) max_addr = 32'(pt_addr0);
         if (a4_en0) begin
            if (pend) begin
               a.key  = lat_key;
               a.maxa = max_addr;
               a.gap  = cyc - rise_cyc;
               att_q.push_back(a);
            end
            pend     = 1'b0;
            lat_key  = a4_key0;
            max_addr = 0;
            n_en0++;
            keys_q.push_back(a4_key0);
         end
         if (a4_rdy0 && !prev_rdy) begin
            pend     = 1'b1;
            rise_cyc = cyc;
            if (a4_key0 !== lat_key) stab_err++;
         end
         if (rdy0) pend = 1'b0;
         prev_en  = a4_en0;
         prev_rdy = a4_rdy0;
      end
   end

   // ---------------- stimulus helpers
   task automatic clear_ptab();
      for (int unsigned k = 0; k < 16; k++)
         for (int unsigned i = 0; i < 256; i++)
            ptab[k][i] = (i == 0) ? 8'd1 : 8'd0;
   endtask

   task automatic set_str(input int unsigned k, input string s);
      ptab[k][0] = 8'(s.len());
      for (int i = 0; i < s.len(); i++) ptab[k][i+1] = s[i];
   endtask

   task automatic search0(input string nm, input bit poke_en);
      int unsigned b_att, b_key, b_en, w0, s0, k, lim, nk, na;
      b_att = att_q.size(); b_key = keys_q.size(); b_en = n_en0;
      w0 = wide_cnt; s0 = stab_err;
      k = 0;
      while (k < 16 && !ok(24'(k))) k++;
      @(negedge clk) en0 = 1'b1;
      @(negedge clk) en0 = 1'b0;
      chk({nm, "_busy"}, 32'(rdy0), 0);
      lim = 0;
      while (!rdy0 && lim < 20000) begin
         en0 = (poke_en && lim == 12);
         @(negedge clk);
         lim++;
      end
      en0 = 1'b0;
      if (!rdy0) begin
         chk({nm, "_timeout"}, 32'(rdy0), 1);
         return;
      end
      chk({nm, "_key"}, 32'(key0), k);
      chk({nm, "_valid"}, 32'(kv0), 1);
      chk({nm, "_attempts"}, n_en0 - b_en, k + 1);
      nk = keys_q.size() - b_key;
      for (int unsigned j = 0; j < nk && j <= k; j++)
         chk({nm, "_try_key"}, 32'(keys_q[b_key + j]), j);
      na = att_q.size() - b_att;
      chk({nm, "_rejects"}, na, k);
      for (int unsigned j = 0; j < na && j < k; j++) begin
         chk({nm, "_rej_addr"}, att_q[b_att + j].maxa, exam(24'(j)));
         chk({nm, "_rej_lat"}, att_q[b_att + j].gap, 4 + 2 * exam(24'(j)));
      end
      chk({nm, "_last_addr"}, max_addr, exam(24'(k)));
      chk({nm, "_last_lat"}, cyc - rise_cyc, 3 + 2 * exam(24'(k)));
      chk({nm, "_en_width"}, wide_cnt - w0, 0);
      chk({nm, "_key_stable"}, stab_err - s0, 0);
      repeat (4) @(negedge clk);
      chk({nm, "_hold_rdy"}, 32'(rdy0), 1);
      chk({nm, "_hold_key"}, 32'(key0), k);
      chk({nm, "_hold_valid"}, 32'(kv0), 1);
   endtask

   // ---------------- directed + random sequence
   initial begin
      int unsigned lim;
      rst = 1'b1; en0 = 1'b0; en1 = 1'b0;
      clear_ptab();
      repeat (3) @(negedge clk);
      chk("rst_rdy", 32'(rdy0), 1);
      chk("rst_key", 32'(key0), 0);
      chk("rst_valid", 32'(kv0), 0);
      chk("rst_a4_en", 32'(a4_en0), 0);
      chk("rst_a4_key", 32'(a4_key0), 0);
      chk("rst_pt_addr", 32'(pt_addr0), 0);
      chk("rst_rdy1", 32'(rdy1), 1);
      rst = 1'b0;

      // single hit at key 3, early rejects before it; en poked mid-search
      set_str(0, "x"); ptab[0][1] = 8'h07;
      set_str(1, "A?B"); ptab[1][2] = 8'h7F;
      set_str(2, "xy");  ptab[2][2] = 8'h1F;
      set_str(3, "HELLO");
      hold_len = 0; busy_len = 5;
      search0("hit", 1'b1);

      // core keeps a4_rdy high for 3 cycles after a4_en
      hold_len = 3; busy_len = 4;
      search0("hold", 1'b0);

      // boundary bytes
      clear_ptab();
      ptab[0][0] = 8'd2; ptab[0][1] = 8'h20; ptab[0][2] = 8'h7F;
      ptab[1][0] = 8'd3; ptab[1][1] = 8'h20; ptab[1][2] = 8'h7E; ptab[1][3] = 8'h41;
      hold_len = 0; busy_len = 2;
      search0("bnd_hi", 1'b0);
      clear_ptab();
      ptab[0][0] = 8'd1; ptab[0][1] = 8'h1F;
      ptab[1][0] = 8'd0;
      search0("len0", 1'b0);

      // len=255, all 'A'
      clear_ptab();
      ptab[0][0] = 8'd255;
      for (int unsigned i = 1; i < 256; i++) ptab[0][i] = 8'h41;
      busy_len = 1;
      search0("len255", 1'b0);

      // reset while arc4 is busy (controller in WAIT_DONE), then restart
      clear_ptab();
      set_str(0, "x"); ptab[0][1] = 8'h07;
      set_str(1, "A?B"); ptab[1][2] = 8'h7F;
      set_str(2, "xy");  ptab[2][2] = 8'h1F;
      set_str(3, "HELLO");
      busy_len = 40;
      @(negedge clk) en0 = 1'b1;
      @(negedge clk) en0 = 1'b0;
      lim = 0;
      while (!a4_en0 && lim < 100) begin
         @(negedge clk);
         lim++;
      end
      chk("rst_seen_a4_en", 32'(a4_en0), 1);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_rdy", 32'(rdy0), 1);
      chk("midrst_valid", 32'(kv0), 0);
      chk("midrst_a4_en", 32'(a4_en0), 0);
      chk("midrst_pt_addr", 32'(pt_addr0), 0);
      chk("midrst_key", 32'(key0), 0);
      rst = 1'b0;
      busy_len = 3;
      search0("restart", 1'b0);

      // random plaintext tables; key 15 always acceptable
      for (int r = 0; r < 4; r++) begin
         clear_ptab();
         for (int unsigned k = 0; k < 15; k++) begin
            ptab[k][0] = 8'($urandom_range(1, 5));
            for (int unsigned i = 1; i <= 32'(ptab[k][0]); i++) begin
               if ($urandom_range(0, 2) == 0)
                  ptab[k][i] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 31))
                                                           : 8'($urandom_range(127, 255));
               else
                  ptab[k][i] = 8'($urandom_range(32, 126));
            end
         end
         ptab[15][0] = 8'($urandom_range(0, 4));
         for (int unsigned i = 1; i <= 4; i++) ptab[15][i] = 8'($urandom_range(32, 126));
         busy_len = $urandom_range(1, 6);
         hold_len = $urandom_range(0, 3);
         search0("rand", 1'b1);
      end

      // exhaustion on the two-key instance
      @(negedge clk) en1 = 1'b1;
      @(negedge clk) en1 = 1'b0;
      lim = 0;
      while (!rdy1 && lim < 1000) begin
         @(negedge clk);
         lim++;
      end
      chk("exh_rdy", 32'(rdy1), 1);
      chk("exh_key", 32'(key1), 32'h00FFFFFF);
      chk("exh_valid", 32'(kv1), 0);
      chk("exh_attempts", n_en1, 2);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
